// File: rtl/option_pkg.sv
// Types and helpers shared by the record parser, the dispatcher and the pricing engines.
package option_pkg;

   localparam int REC_W   = 200;
   localparam int MAX_ENG = 8;

   typedef struct packed {
      logic [31:0] option_id;
      logic [31:0] sptprice;
      logic [31:0] strike;
      logic [31:0] rate;
      logic [31:0] volatility;
      logic [31:0] otime;
      logic [7:0]  otype;
   } option_rec_t;

   typedef enum logic [1:0] {
      ENG_IDLE = 2'd0,
      ENG_RUN  = 2'd1,
      ENG_HOLD = 2'd2
   } eng_state_e;

   // Returns {found, index} of the first set req bit at or after ptr, wrapping at n.
   // Scanning offsets from high to low lets the smallest offset win.
   function automatic logic [3:0] rr_pick(input logic [MAX_ENG-1:0] req,
                                          input logic [2:0] ptr, input int n);
      logic [3:0] r;
      int         idx;
      r = '0;
      for (int k = MAX_ENG - 1; k >= 0; k--) begin
         if (k < n) begin
            idx = int'(ptr) + k;
            if (idx >= n) idx = idx - n;
            if (req[idx]) r = {1'b1, 3'(idx)};
         end
      end
      return r;
   endfunction

   function automatic logic [2:0] rr_next(input logic [2:0] idx, input int n);
      return (int'(idx) + 1 >= n) ? 3'd0 : idx + 3'd1;
   endfunction

endpackage

// File: rtl/option_dispatch_if.sv
// Parser-side record input, engine bank and result port of the option dispatcher.
interface option_dispatch_if
   import option_pkg::*;
   #(parameter int NUM_ENGINES = 4) ();

   logic                     rec_valid;
   logic [31:0]              rec_option_id;
   logic [31:0]              rec_sptprice;
   logic [31:0]              rec_strike;
   logic [31:0]              rec_rate;
   logic [31:0]              rec_volatility;
   logic [31:0]              rec_otime;
   logic [7:0]               rec_otype;
   logic                     overflow;
   logic                     proto_err;
   logic [NUM_ENGINES-1:0]   eng_start;
   option_rec_t              eng_record;
   logic [NUM_ENGINES-1:0]   eng_done;
   logic [32*NUM_ENGINES-1:0] eng_price;
   logic                     res_valid;
   logic                     res_ready;
   logic [31:0]              res_option_id;
   logic [31:0]              res_price;

   modport master (
      input  rec_valid, rec_option_id, rec_sptprice, rec_strike, rec_rate,
             rec_volatility, rec_otime, rec_otype, eng_done, eng_price, res_ready,
      output overflow, proto_err, eng_start, eng_record, res_valid,
             res_option_id, res_price
   );

   modport slave (
      output rec_valid, rec_option_id, rec_sptprice, rec_strike, rec_rate,
             rec_volatility, rec_otime, rec_otype, eng_done, eng_price, res_ready,
      input  overflow, proto_err, eng_start, eng_record, res_valid,
             res_option_id, res_price
   );

endinterface

// File: rtl/option_fifo.sv
// Synchronous first-word-fall-through FIFO of option records.
module option_fifo
   import option_pkg::*;
   #(parameter int DEPTH = 8)
   (
      input  logic        clk,
      input  logic        rst,
      input  logic        push,
      input  logic        pop,
      input  option_rec_t din,
      output option_rec_t dout,
      output logic        full,
      output logic        empty
   );

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

   logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   option_rec_t mem_q [DEPTH];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) wr_ptr_d = wr_ptr_q + ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + ONE;
   end

   // The extra pointer bit distinguishes full from empty when the indices match.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign dout  = mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= din;
   end

endmodule

// File: rtl/option_dispatch.sv
// Buffers parsed option records, hands them round-robin to free pricing engines,
// and returns (option_id, price) results one at a time over a valid/ready port.
module option_dispatch
   import option_pkg::*;
   #(
      parameter int NUM_ENGINES = 4,
      parameter int FIFO_DEPTH  = 8
   )
   (
      input  logic               clk,
      input  logic               rst,
      option_dispatch_if.master  bus
   );

   option_rec_t rec_in, fifo_dout;
   logic        fifo_push, fifo_pop, fifo_full, fifo_empty, res_hs;

   eng_state_e  eng_state_q [NUM_ENGINES];
   eng_state_e  eng_state_d [NUM_ENGINES];
   logic [31:0] tag_q   [NUM_ENGINES];
   logic [31:0] tag_d   [NUM_ENGINES];
   logic [31:0] price_q [NUM_ENGINES];
   logic [31:0] price_d [NUM_ENGINES];

   logic [2:0]  disp_ptr_q, disp_ptr_d, res_ptr_q, res_ptr_d, res_idx_q, res_idx_d;
   logic [NUM_ENGINES-1:0] eng_start_q, eng_start_d;
   option_rec_t eng_record_q, eng_record_d;
   logic        res_valid_q, res_valid_d, overflow_q, overflow_d, proto_err_q, proto_err_d;
   logic [31:0] res_option_id_q, res_option_id_d, res_price_q, res_price_d;

   logic [MAX_ENG-1:0] idle_vec, hold_vec;
   logic [3:0]         disp_pick, res_pick;

   assign rec_in = '{option_id:  bus.rec_option_id,
                     sptprice:   bus.rec_sptprice,
                     strike:     bus.rec_strike,
                     rate:       bus.rec_rate,
                     volatility: bus.rec_volatility,
                     otime:      bus.rec_otime,
                     otype:      bus.rec_otype};

   option_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (rec_in),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      idle_vec = '0;
      hold_vec = '0;
      for (int i = 0; i < NUM_ENGINES; i++) begin
         idle_vec[i] = (eng_state_q[i] == ENG_IDLE);
         hold_vec[i] = (eng_state_q[i] == ENG_HOLD);
      end
   end

   assign disp_pick = rr_pick(idle_vec, disp_ptr_q, NUM_ENGINES);
   assign res_pick  = rr_pick(hold_vec, res_ptr_q, NUM_ENGINES);
   assign fifo_pop  = !fifo_empty && disp_pick[3];
   // A full FIFO still takes a record when the head leaves in the same cycle.
   assign fifo_push = bus.rec_valid && (!fifo_full || fifo_pop);
   assign res_hs    = res_valid_q && bus.res_ready;

   always_comb begin
      eng_state_d     = eng_state_q;
      tag_d           = tag_q;
      price_d         = price_q;
      disp_ptr_d      = disp_ptr_q;
      res_ptr_d       = res_ptr_q;
      res_idx_d       = res_idx_q;
      eng_start_d     = '0;
      eng_record_d    = eng_record_q;
      res_valid_d     = res_valid_q;
      res_option_id_d = res_option_id_q;
      res_price_d     = res_price_q;
      overflow_d      = overflow_q | (bus.rec_valid && !fifo_push);
      proto_err_d     = proto_err_q;

      // Completion, dispatch and release touch disjoint states, so order is irrelevant.
      for (int i = 0; i < NUM_ENGINES; i++) begin
         if (bus.eng_done[i]) begin
            if (eng_state_q[i] == ENG_RUN) begin
               eng_state_d[i] = ENG_HOLD;
               price_d[i]     = bus.eng_price[32*i +: 32];
            end else begin
               proto_err_d = 1'b1;
            end
         end
         if (fifo_pop && disp_pick[2:0] == 3'(i)) begin
            eng_state_d[i] = ENG_RUN;
            tag_d[i]       = fifo_dout.option_id;
            eng_start_d[i] = 1'b1;
         end
         if (res_hs && res_idx_q == 3'(i)) eng_state_d[i] = ENG_IDLE;
      end

      if (fifo_pop) begin
         eng_record_d = fifo_dout;
         disp_ptr_d   = rr_next(disp_pick[2:0], NUM_ENGINES);
      end

      if (res_hs) begin
         res_valid_d = 1'b0;
         res_ptr_d   = rr_next(res_idx_q, NUM_ENGINES);
      end else if (!res_valid_q && res_pick[3]) begin
         res_valid_d = 1'b1;
         res_idx_d   = res_pick[2:0];
         for (int i = 0; i < NUM_ENGINES; i++) begin
            if (res_pick[2:0] == 3'(i)) begin
               res_option_id_d = tag_q[i];
               res_price_d     = price_q[i];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_ENGINES; i++) begin
            eng_state_q[i] <= ENG_IDLE;
            tag_q[i]       <= '0;
            price_q[i]     <= '0;
         end
         disp_ptr_q      <= '0;
         res_ptr_q       <= '0;
         res_idx_q       <= '0;
         eng_start_q     <= '0;
         eng_record_q    <= '0;
         res_valid_q     <= 1'b0;
         res_option_id_q <= '0;
         res_price_q     <= '0;
         overflow_q      <= 1'b0;
         proto_err_q     <= 1'b0;
      end else begin
         eng_state_q     <= eng_state_d;
         tag_q           <= tag_d;
         price_q         <= price_d;
         disp_ptr_q      <= disp_ptr_d;
         res_ptr_q       <= res_ptr_d;
         res_idx_q       <= res_idx_d;
         eng_start_q     <= eng_start_d;
         eng_record_q    <= eng_record_d;
         res_valid_q     <= res_valid_d;
         res_option_id_q <= res_option_id_d;
         res_price_q     <= res_price_d;
         overflow_q      <= overflow_d;
         proto_err_q     <= proto_err_d;
      end
   end

   assign bus.eng_start     = eng_start_q;
   assign bus.eng_record    = eng_record_q;
   assign bus.res_valid     = res_valid_q;
   assign bus.res_option_id = res_option_id_q;
   assign bus.res_price     = res_price_q;
   assign bus.overflow      = overflow_q;
   assign bus.proto_err     = proto_err_q;

endmodule

// File: tb/tb_option_dispatch.sv
// Directed bench for option_dispatch: 4 engines, 8-entry FIFO, hand-computed expectations.
module tb_option_dispatch;
   import option_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   option_dispatch_if #(.NUM_ENGINES(4)) bus ();

   option_dispatch #(.NUM_ENGINES(4), .FIFO_DEPTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic option_rec_t mkrec(input logic [31:0] id);
      option_rec_t r;
      r.option_id  = id;
      r.sptprice   = 32'h42C80000;
      r.strike     = 32'h42A00000 ^ id;
      r.rate       = 32'h3CF5C28F;
      r.volatility = 32'h3E99999A;
      r.otime      = 32'h3F000000 + id;
      r.otype      = id[7:0];
      return r;
   endfunction

   task automatic drive_rec(input logic [31:0] id);
      option_rec_t r;
      r = mkrec(id);
      bus.rec_valid      = 1'b1;
      bus.rec_option_id  = r.option_id;
      bus.rec_sptprice   = r.sptprice;
      bus.rec_strike     = r.strike;
      bus.rec_rate       = r.rate;
      bus.rec_volatility = r.volatility;
      bus.rec_otime      = r.otime;
      bus.rec_otype      = r.otype;
   endtask

   task automatic done(input logic [3:0] m, input logic [127:0] p);
      bus.eng_done  = m;
      bus.eng_price = p;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_start"},     bus.eng_start, 0);
      chk({tag, "_record"},    bus.eng_record, 0);
      chk({tag, "_res_valid"}, bus.res_valid, 0);
      chk({tag, "_res_id"},    bus.res_option_id, 0);
      chk({tag, "_res_price"}, bus.res_price, 0);
      chk({tag, "_overflow"},  bus.overflow, 0);
      chk({tag, "_proto_err"}, bus.proto_err, 0);
   endtask

   initial begin
      rst = 1'b1;
      bus.rec_valid = 1'b0;
      bus.rec_option_id = '0; bus.rec_sptprice = '0; bus.rec_strike = '0;
      bus.rec_rate = '0; bus.rec_volatility = '0; bus.rec_otime = '0; bus.rec_otype = '0;
      bus.eng_done = '0; bus.eng_price = '0; bus.res_ready = 1'b0;
      tick();
      rst = 1'b0;
      chk_all_zero("reset");

      // single record through engine 0
      drive_rec(32'h1); tick(); bus.rec_valid = 1'b0;
      chk("t1_no_start_yet", bus.eng_start, 4'b0000);
      tick();
      chk("t1_start", bus.eng_start, 4'b0001);
      chk("t1_record", bus.eng_record, mkrec(32'h1));
      tick();
      chk("t1_start_pulse", bus.eng_start, 4'b0000);
      done(4'b0001, {96'h0, 32'h41200000}); tick(); done(4'b0, '0);
      chk("t1_no_res_yet", bus.res_valid, 1'b0);
      tick();
      chk("t1_res_valid", bus.res_valid, 1'b1);
      chk("t1_res_id", bus.res_option_id, 32'h1);
      chk("t1_res_price", bus.res_price, 32'h41200000);
      tick();
      chk("t1_res_hold", bus.res_valid, 1'b1);
      bus.res_ready = 1'b1; tick(); bus.res_ready = 1'b0;
      chk("t1_res_drop", bus.res_valid, 1'b0);

      // done on an idle engine
      rst = 1'b1; tick(); rst = 1'b0;
      chk("pe_clear", bus.proto_err, 1'b0);
      done(4'b1000, {32'h0BAD0000, 96'h0}); tick(); done(4'b0, '0);
      chk("pe_set", bus.proto_err, 1'b1);
      tick();
      chk("pe_no_res", bus.res_valid, 1'b0);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("pe_reset", bus.proto_err, 1'b0);

      // five back-to-back records
      drive_rec(32'h1); tick();
      drive_rec(32'h2); tick();
      chk("t2_s0", bus.eng_start, 4'b0001); chk("t2_r0", bus.eng_record, mkrec(32'h1));
      drive_rec(32'h3); tick();
      chk("t2_s1", bus.eng_start, 4'b0010); chk("t2_r1", bus.eng_record, mkrec(32'h2));
      drive_rec(32'h4); tick();
      chk("t2_s2", bus.eng_start, 4'b0100); chk("t2_r2", bus.eng_record, mkrec(32'h3));
      drive_rec(32'h5); tick();
      chk("t2_s3", bus.eng_start, 4'b1000); chk("t2_r3", bus.eng_record, mkrec(32'h4));
      bus.rec_valid = 1'b0; tick();
      chk("t2_all_busy", bus.eng_start, 4'b0000);
      done(4'b0001, {96'h0, 32'h40000001}); tick(); done(4'b0, '0); tick();
      chk("t2_res_valid", bus.res_valid, 1'b1);
      chk("t2_res_id", bus.res_option_id, 32'h1);
      chk("t2_res_price", bus.res_price, 32'h40000001);
      chk("t2_id5_waits", bus.eng_start, 4'b0000);
      bus.res_ready = 1'b1; tick(); bus.res_ready = 1'b0;
      chk("t2_res_drop", bus.res_valid, 1'b0);
      chk("t2_id5_waits2", bus.eng_start, 4'b0000);
      tick();
      chk("t2_s5", bus.eng_start, 4'b0001); chk("t2_r5", bus.eng_record, mkrec(32'h5));

      // out-of-order completion, result pointer at 1
      done(4'b0100, {32'h0, 32'h33330002, 64'h0}); tick();
      done(4'b0011, {64'h0, 32'h33330001, 32'h33330000}); tick(); done(4'b0, '0);
      chk("t3_a_valid", bus.res_valid, 1'b1);
      chk("t3_a_id", bus.res_option_id, 32'h3);
      chk("t3_a_price", bus.res_price, 32'h33330002);
      tick();
      chk("t3_a_stable_id", bus.res_option_id, 32'h3);
      chk("t3_a_stable_v", bus.res_valid, 1'b1);
      bus.res_ready = 1'b1; tick();
      chk("t3_a_drop", bus.res_valid, 1'b0);
      tick();
      chk("t3_b_id", bus.res_option_id, 32'h5);
      chk("t3_b_price", bus.res_price, 32'h33330000);
      tick();
      chk("t3_b_drop", bus.res_valid, 1'b0);
      tick();
      chk("t3_c_id", bus.res_option_id, 32'h2);
      chk("t3_c_price", bus.res_price, 32'h33330001);
      tick(); bus.res_ready = 1'b0;
      chk("t3_c_drop", bus.res_valid, 1'b0);
      tick();
      chk("t3_no_more", bus.res_valid, 1'b0);

      // fill engines and FIFO (engine 3 still running id 4)
      for (int k = 0; k < 11; k++) begin
         drive_rec(32'h21 + 32'(k)); tick();
         if (k == 1) begin
            chk("t4_s21", bus.eng_start, 4'b0010);
            chk("t4_r21", bus.eng_record, mkrec(32'h21));
         end
      end
      bus.rec_valid = 1'b0;
      chk("t4_full_no_ovf", bus.overflow, 1'b0);
      done(4'b1000, {32'h44440003, 96'h0}); tick(); done(4'b0, '0); tick();
      chk("t4_res_id", bus.res_option_id, 32'h4);
      chk("t4_res_price", bus.res_price, 32'h44440003);
      bus.res_ready = 1'b1; tick(); bus.res_ready = 1'b0;
      drive_rec(32'h2C); tick();
      chk("t4_pop_start", bus.eng_start, 4'b1000);
      chk("t4_pop_record", bus.eng_record, mkrec(32'h24));
      chk("t4_push_pop_ovf", bus.overflow, 1'b0);
      drive_rec(32'h2D); tick(); bus.rec_valid = 1'b0;
      chk("t4_overflow", bus.overflow, 1'b1);
      chk("t4_no_start", bus.eng_start, 4'b0000);

      // reset mid-operation
      done(4'b0110, {32'h0, 32'h55550002, 32'h55550001, 32'h0}); tick(); done(4'b0, '0); tick();
      chk("t6_pre_valid", bus.res_valid, 1'b1);
      chk("t6_pre_id", bus.res_option_id, 32'h21);
      rst = 1'b1; done(4'b0001, {96'h0, 32'h66660000}); tick(); rst = 1'b0; done(4'b0, '0);
      chk_all_zero("t6_reset");
      tick();
      chk("t6_fifo_empty", bus.eng_start, 4'b0000);
      done(4'b1001, {32'h77770003, 64'h0, 32'h77770000}); tick(); done(4'b0, '0);
      chk("t6_proto_err", bus.proto_err, 1'b1);
      tick();
      chk("t6_no_res", bus.res_valid, 1'b0);
      drive_rec(32'h77); tick(); bus.rec_valid = 1'b0; tick();
      chk("t6_fresh_start", bus.eng_start, 4'b0001);
      chk("t6_fresh_record", bus.eng_record, mkrec(32'h77));
      chk("t6_res_still_none", bus.res_valid, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
